// File: rtl/inst_fetch.sv
// Instruction fetch: PC, one-cycle-latency memory port and a 2-entry {pc, inst} FIFO to decode.
// Optional HALT detection (opcode 4'b1000) is built when INST_FETCH_HALT_DETECT_EN is defined.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  mem_addr,
    output logic        mem_req,
    input  logic [15:0] mem_data,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_data,
    output logic [7:0]  inst_pc,
    output logic        halted
);

    logic [7:0]  pc;
    logic [1:0]  count, count_n, base;
    logic [7:0]  q_pc [2];
    logic [15:0] q_data [2];
    logic [7:0]  q_pc_n [2];
    logic [15:0] q_data_n [2];
    logic        inflight;
    logic [7:0]  inflight_pc;
    logic        halted_q;
    logic        pop, wr;
    logic [2:0]  occ;

    assign inst_valid = !rst && (count != 2'd0);
    assign inst_data  = rst ? 16'h0 : q_data[0];
    assign inst_pc    = rst ? 8'h0 : q_pc[0];
    assign mem_addr   = rst ? 8'h0 : pc;
    assign halted     = !rst && halted_q;

    assign pop = inst_valid && inst_ready;
    // A returning word is dropped if a redirect flushes it or fetch already halted.
    assign wr  = inflight && !redirect_valid && !halted_q;
    assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign mem_req = !rst && !halted_q && !redirect_valid && (occ < 3'd2);

`ifdef INST_FETCH_HALT_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst || redirect_valid)
            halted_q <= 1'b0;
        else if (wr && mem_data[15:12] == 4'b1000)
            halted_q <= 1'b1;
    end
`else
    assign halted_q = 1'b0;
`endif

    // Pop shifts entry 1 to the head; a write lands just behind what survives the pop.
    always_comb begin
        q_pc_n   = q_pc;
        q_data_n = q_data;
        base     = count - {1'b0, pop};
        if (pop) begin
            q_pc_n[0]   = q_pc[1];
            q_data_n[0] = q_data[1];
        end
        if (wr) begin
            q_pc_n[base[0]]   = inflight_pc;
            q_data_n[base[0]] = mem_data;
        end
        count_n = redirect_valid ? 2'd0 : base + {1'b0, wr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= 8'h0;
            count       <= 2'd0;
            inflight    <= 1'b0;
            inflight_pc <= 8'h0;
            for (int i = 0; i < 2; i++) begin
                q_pc[i]   <= 8'h0;
                q_data[i] <= 16'h0;
            end
        end else begin
            inflight    <= mem_req;
            inflight_pc <= pc;
            if (redirect_valid)
                pc <= redirect_addr;
            else if (mem_req)
                pc <= pc + 8'd1;
            count  <= count_n;
            q_pc   <= q_pc_n;
            q_data <= q_data_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, backpressure, redirect, wrap, mid-stream reset, HALT.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic [15:0] mem_data = 16'h0;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [7:0]  inst_pc;
    logic        halted;
    logic        plant;
    int          vecs = 0;
    int          errs = 0;
    logic [7:0]  wrap_pc [4];

    inst_fetch dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory: mem[n] = 16'h0400 + n, optionally with a HALT word planted at address 7.
    always @(posedge clk)
        if (mem_req)
            mem_data <= (plant && mem_addr == 8'd7) ? 16'h8000 : 16'h0400 + {8'h0, mem_addr};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Leaves the caller 1ns into the first cycle with rst=0 (cycle C0).
    task automatic rst_seq();
        step(); rst = 1'b1;
        step(); step(); rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h0; inst_ready = 1'b1; plant = 1'b0;
        wrap_pc[0] = 8'hFE; wrap_pc[1] = 8'hFF; wrap_pc[2] = 8'h00; wrap_pc[3] = 8'h01;

        // Reset state, with a redirect that reset must override
        step(); redirect_valid = 1'b1; redirect_addr = 8'h33;
        step(); #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_halted", halted, 0);
        redirect_valid = 1'b0;

        // Streaming from reset release
        step(); rst = 1'b0; #1;
        chk("c0_req", mem_req, 1);
        chk("c0_addr", mem_addr, 0);
        step();
        chk("c1_valid", inst_valid, 0);
        chk("c1_addr", mem_addr, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_valid", inst_valid, 1);
            chk("stream_pc", inst_pc, 16'(i));
            chk("stream_data", inst_data, 16'h0400 + 16'(i));
        end

        // Backpressure for 5 cycles after first valid
        rst_seq(); step(); step();
        inst_ready = 1'b0; #1;
        chk("bp_pc", inst_pc, 0);
        chk("bp_req", mem_req, 0);
        for (int k = 3; k <= 6; k++) begin
            step();
            chk("bp_hold_pc", inst_pc, 0);
            chk("bp_hold_data", inst_data, 16'h0400);
            chk("bp_hold_req", mem_req, 0);
        end
        step(); inst_ready = 1'b1; #1;
        chk("bp_rel_pc0", inst_pc, 0);
        chk("bp_rel_req", mem_req, 1);
        chk("bp_rel_addr", mem_addr, 2);
        step(); chk("bp_rel_pc1", inst_pc, 1);
        step(); chk("bp_rel_pc2", inst_pc, 2);
        step(); chk("bp_rel_pc3", inst_pc, 3);

        // Redirect to 0x40 while FIFO holds pcs 5,6
        rst_seq();
        for (int k = 0; k < 7; k++) step();
        inst_ready = 1'b0; #1;
        chk("rd_head5", inst_pc, 5);
        step(); redirect_valid = 1'b1; redirect_addr = 8'h40; #1;
        chk("rd_cycle_req", mem_req, 0);
        chk("rd_cycle_pc", inst_pc, 5);
        step(); redirect_valid = 1'b0; inst_ready = 1'b1; #1;
        chk("rd_next_valid", inst_valid, 0);
        chk("rd_next_req", mem_req, 1);
        chk("rd_next_addr", mem_addr, 16'h40);
        step(); chk("rd_gap_valid", inst_valid, 0);
        step();
        chk("rd_pc40", inst_pc, 16'h40);
        chk("rd_data40", inst_data, 16'h0440);
        step(); chk("rd_pc41", inst_pc, 16'h41);

        // Redirect with wrap at 255
        step(); redirect_valid = 1'b1; redirect_addr = 8'hFE; #1;
        chk("wrap_rd_req", mem_req, 0);
        step(); redirect_valid = 1'b0; #1;
        chk("wrap_valid0", inst_valid, 0);
        chk("wrap_addr", mem_addr, 16'hFE);
        step(); chk("wrap_valid1", inst_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap_pc", inst_pc, {8'h0, wrap_pc[i]});
            chk("wrap_data", inst_data, 16'h0400 + {8'h0, wrap_pc[i]});
        end

        // Reset mid-stream with FIFO full
        rst_seq(); step(); step();
        inst_ready = 1'b0;
        step();
        chk("mr_full_pc", inst_pc, 0);
        step(); rst = 1'b1; #1;
        chk("mr_rst_valid", inst_valid, 0);
        chk("mr_rst_req", mem_req, 0);
        step(); rst = 1'b0; inst_ready = 1'b1; #1;
        chk("mr_valid", inst_valid, 0);
        chk("mr_addr", mem_addr, 0);
        chk("mr_halted", halted, 0);
        chk("mr_req", mem_req, 1);
        step(); chk("mr_gap", inst_valid, 0);
        step();
        chk("mr_pc0", inst_pc, 0);
        chk("mr_data0", inst_data, 16'h0400);

        // HALT word at address 7
        plant = 1'b1;
        rst_seq();
        for (int k = 0; k < 9; k++) step();
        chk("halt_pc7", inst_pc, 7);
        chk("halt_data7", inst_data, 16'h8000);
`ifdef INST_FETCH_HALT_DETECT_EN
        chk("halt_set", halted, 1);
        chk("halt_req", mem_req, 0);
        step();
        chk("halt_novalid", inst_valid, 0);
        chk("halt_noreq", mem_req, 0);
        chk("halt_hold", halted, 1);
        step();
        chk("halt_novalid2", inst_valid, 0);
        chk("halt_noreq2", mem_req, 0);
        step(); redirect_valid = 1'b1; redirect_addr = 8'h00; #1;
        chk("halt_rd_req", mem_req, 0);
        step(); redirect_valid = 1'b0; #1;
        chk("halt_clear", halted, 0);
        chk("halt_resume_req", mem_req, 1);
        chk("halt_resume_addr", mem_addr, 0);
        step(); step();
        chk("halt_resume_pc", inst_pc, 0);
        chk("halt_resume_data", inst_data, 16'h0400);
`else
        chk("nohalt_flag", halted, 0);
        step();
        chk("nohalt_pc8", inst_pc, 8);
        chk("nohalt_data8", inst_data, 16'h0408);
        chk("nohalt_flag2", halted, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port mem_addr, output, 8 bits: instruction memory word address.
REQ-004 SHALL have port mem_req, output, 1 bit: mem_addr is issued this cycle.
REQ-005 SHALL have port mem_data, input, 16 bits: instruction word, valid one cycle after the matching mem_req.
REQ-006 SHALL have port redirect_valid, input, 1 bit: branch/jump taken.
REQ-007 SHALL have port redirect_addr, input, 8 bits: new fetch target.
REQ-008 SHALL have port inst_valid, output, 1 bit: inst_data and inst_pc hold an instruction.
REQ-009 SHALL have port inst_ready, input, 1 bit: decode accepts the instruction.
REQ-010 SHALL have port inst_data, output, 16 bits: instruction word at FIFO head.
REQ-011 SHALL have port inst_pc, output, 8 bits: address of inst_data.
REQ-012 SHALL have port halted, output, 1 bit: fetch stopped on HALT (see Configuration).

Function
REQ-013 SHALL hold an 8-bit PC and a 2-entry FIFO of {pc, instruction}; inst_* outputs present the FIFO head.
REQ-014 SHALL drive mem_addr = PC combinationally; a cycle with mem_req=1 is an issue, and PC increments by 1 mod 256 (255 -> 0).
REQ-015 SHALL assert mem_req when not halted, redirect_valid=0, and (FIFO count + in-flight - pop this cycle) < 2; pop = inst_valid & inst_ready.
REQ-016 SHALL write mem_data with its issue address into the FIFO on the cycle after an issue, unless that in-flight word is marked discarded.
REQ-017 SHALL give latency issue -> inst_valid of 2 cycles; sustained throughput 1 instruction/cycle when inst_ready=1.
REQ-018 SHALL hold inst_data and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-019 On redirect_valid=1: PC <= redirect_addr, FIFO flushed, any in-flight word discarded, halted cleared, mem_req=0 that cycle; the first issue from redirect_addr occurs on the next cycle.
REQ-020 A pop in the same cycle as a redirect SHALL complete (decode consumes the head); the flush then removes all remaining entries.
REQ-021 Simultaneous FIFO write and pop SHALL keep count unchanged; the FIFO SHALL never exceed 2 entries or underflow.
REQ-022 inst_valid SHALL be 0 in the cycle after a redirect.

Reset
REQ-023 While rst=1: PC=0, FIFO empty, in-flight cleared, mem_req=0, mem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, halted=0.
REQ-024 rst SHALL override redirect_valid and any in-progress fetch; the first issue (addr 0) occurs in the first cycle with rst=0.

Configuration
REQ-025 With macro INST_FETCH_HALT_DETECT_EN defined: a word with mem_data[15:12]=4'b1000 written to the FIFO sets halted; no further issues; any younger in-flight word is discarded; the HALT word itself is still delivered; halted clears only on redirect or reset.
REQ-026 Without INST_FETCH_HALT_DETECT_EN: halted is tied 0 and opcode 4'b1000 is fetched like any other word.

Verification
REQ-027 Reset release, memory holds mem[n]=16'h0400+n, inst_ready=1 -> inst_valid rises 2 cycles after first issue; inst_pc 0,1,2,... with inst_data 16'h0400, 16'h0401, ... one per cycle.
REQ-028 inst_ready=0 for 5 cycles after first valid -> mem_req drops once FIFO+in-flight=2; inst_pc stays 0; on release, pcs 0,1,2 delivered with no gap or duplicate.
REQ-029 redirect_valid=1, redirect_addr=8'h40 while FIFO holds pcs 5,6 -> inst_valid=0 next cycle; next delivered inst_pc=8'h40; pcs 5,6 never appear after the redirect cycle.
REQ-030 redirect_addr=8'hFE, inst_ready=1 -> inst_pc sequence 8'hFE, 8'hFF, 8'h00, 8'h01.
REQ-031 With INST_FETCH_HALT_DETECT_EN, mem[7]=16'h8000 -> pc 7 delivered, halted=1, no mem_req afterwards, no pc 8; redirect to 8'h00 clears halted and resumes fetch; without the macro, pc 8 follows pc 7.
REQ-032 rst=1 asserted mid-stream with FIFO full -> next cycle inst_valid=0, mem_addr=0, halted=0; after release, delivery restarts at inst_pc 0.
